// File: rtl/ff_fifo_packer_pkg.sv
// Shared types and helpers for the FIFO word packer.
package ff_fifo_packer_pkg;

   typedef enum logic {
      ACCUM   = 1'b0,
      PENDING = 1'b1
   } packer_state_t;

   localparam int unsigned max_ratio = 32;

   // Contiguous lane-valid mask with the lowest 'count' lanes set, limited to 'ratio' lanes.
   function automatic logic [max_ratio-1:0] keep_mask(input int unsigned count,
                                                      input int unsigned ratio);
      logic [max_ratio-1:0] mask;
      mask = '0;
      for (int unsigned i = 0; i < max_ratio; i++) begin
         mask[i] = (i < count) && (i < ratio);
      end
      return mask;
   endfunction

endpackage

// File: rtl/ff_fifo_packer_flush_timer.sv
// Idle counter that force-closes a partial word after 'timeout' idle cycles.
// expire is combinational: it marks the cycle whose edge completes the timeout-th idle cycle.
module ff_fifo_packer_flush_timer #(
   parameter int timeout = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expire
);

   localparam int tw = (timeout < 2) ? 1 : $clog2(timeout + 1);

   logic [tw-1:0] count;

   assign expire = start && !clear && (count == tw'(timeout - 1));

   // Count idle cycles while running; any clear, stop or expiry returns to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || !start || expire) begin
         count <= '0;
      end else begin
         count <= count + tw'(1);
      end
   end

endmodule

// File: rtl/ff_fifo_word_packer.sv
// Packs 'ratio' narrow input words into one wide FIFO word with a lane-valid mask.
// Optional idle flush of partial words: define FF_FIFO_PACKER_FLUSH_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ACCUM   | collecting lanes; cnt = lanes already written (0..ratio-1)
// PENDING | word closed, data/keep frozen until the FIFO takes it
module ff_fifo_word_packer
   import ff_fifo_packer_pkg::*;
#(
   parameter  int in_width      = 8,
   parameter  int ratio         = 4,
   parameter  int flush_timeout = 16,
   localparam int out_width     = in_width * ratio
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic [in_width-1:0]  in_data,
   output logic                 in_ready,
   input  logic                 fifo_full,
   output logic                 fifo_push,
   output logic [out_width-1:0] fifo_write_data,
   output logic [ratio-1:0]     fifo_write_keep
);

   localparam int cnt_w = $clog2(ratio);

   packer_state_t        state, state_d;
   logic [cnt_w-1:0]     cnt, cnt_d;
   logic [out_width-1:0] data, data_d;
   logic [ratio-1:0]     keep, keep_d;
   logic                 accept;
   logic                 last_lane;
   logic                 expire;

   assign in_ready        = (state == ACCUM) || !fifo_full;
   assign fifo_push       = (state == PENDING) && !fifo_full;
   assign accept          = in_valid && in_ready;
   assign last_lane       = (cnt == cnt_w'(ratio - 1));
   assign fifo_write_data = data;
   assign fifo_write_keep = keep;

`ifdef FF_FIFO_PACKER_FLUSH_TIMEOUT_EN
   logic timer_start;
   logic timer_clear;

   assign timer_start = (state == ACCUM) && (cnt != '0) && !accept;
   assign timer_clear = accept || (state != ACCUM);

   ff_fifo_packer_flush_timer #(
      .timeout (flush_timeout)
   ) u_flush_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (timer_start),
      .clear  (timer_clear),
      .expire (expire)
   );
`else
   assign expire = 1'b0;
`endif

   // Next-state, lane write and mask update.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      data_d  = data;
      keep_d  = keep;
      case (state)
         ACCUM: begin
            if (accept) begin
               data_d[int'(cnt)*in_width +: in_width] = in_data;
               keep_d = ratio'(keep_mask(int'(cnt) + 1, ratio));
               if (last_lane || in_last) begin
                  state_d = PENDING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + cnt_w'(1);
               end
            end else if (expire) begin
               state_d = PENDING;
               cnt_d   = '0;
            end
         end
         PENDING: begin
            if (fifo_push) begin
               state_d = ACCUM;
               cnt_d   = '0;
               data_d  = '0;
               keep_d  = '0;
               // A beat arriving in the push cycle opens the next word without a bubble.
               if (accept) begin
                  data_d[in_width-1:0] = in_data;
                  keep_d = ratio'(keep_mask(1, ratio));
                  if (in_last) begin
                     state_d = PENDING;
                  end else begin
                     cnt_d = cnt_w'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // State and word registers; reset discards any partial or pending word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACCUM;
         cnt   <= '0;
         data  <= '0;
         keep  <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         data  <= data_d;
         keep  <= keep_d;
      end
   end

endmodule

// File: doc/ff_fifo_word_packer.md
# ff_fifo_word_packer

Upstream stage for the power-of-two-depth flip-flop FIFO. Accepts a stream of narrow words over a valid/ready handshake and packs `ratio` consecutive words into one wide word. Pushes each complete word, or a partial word closed by `in_last`, into the FIFO together with a lane-valid mask. Backpressure comes from the FIFO `full` flag.

## Interface

- `in_width`, default 8: width of one input lane.
- `ratio`, default 4: lanes per output word; must be ≥ 2.
- `flush_timeout`, default 16: idle cycles before a partial word is force-closed; used only with the macro; must be ≥ 1.
- Derived localparam `out_width = in_width * ratio`. The FIFO instance is sized `width = out_width + ratio`.
- Reset `rst`, asynchronous, active-high; clock `clk`.
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous active-high reset.
- `in_valid`, input, 1: input word present.
- `in_last`, input, 1: this input word closes the current packet.
- `in_data`, input, `in_width`: input word.
- `in_ready`, output, 1: the block accepts the input word this cycle.
- `fifo_full`, input, 1: FIFO `full` flag.
- `fifo_push`, output, 1: FIFO push strobe.
- `fifo_write_data`, output, `out_width`: packed word.
- `fifo_write_keep`, output, `ratio`: lane-valid mask.

## Operation

- A beat is accepted when `in_valid & in_ready` at a rising clock edge.
- States:
  - `ACCUM`: collecting; lane count `cnt` in 0..ratio-1.
  - `PENDING`: word closed, waiting to be pushed.
- Packing:
  - Accepted beat k of a word is written to lane k, bits `[k*in_width +: in_width]`.
  - Lane 0 is the first beat (little-endian).
  - Lanes not written are 0.
  - `fifo_write_keep` bit k is 1 iff lane k was written. The mask is always contiguous from bit 0.
- Transitions:
  - `ACCUM` → `PENDING` when a beat is accepted with `cnt == ratio-1` or with `in_last = 1`.
  - Otherwise an accepted beat increments `cnt`.
- Push:
  - `fifo_push = PENDING & ~fifo_full`.
  - On a push with no beat accepted in the same cycle: data, keep and `cnt` clear; state returns to `ACCUM`.
- Ready:
  - `in_ready = (state == ACCUM) | ~fifo_full`.
  - A beat accepted while in `PENDING` with a push that cycle starts the next word in lane 0 with `cnt` = 1. If that beat also closes the word (`in_last`), the state stays `PENDING`.
- `fifo_write_data` and `fifo_write_keep` come straight from registers. They are stable throughout `PENDING`.
- A `PENDING` word held by `fifo_full` is never modified or dropped.
- An empty word is never pushed. `in_last` with no prior lanes gives keep = one lane.

## Timing

- Reset values:
  - state `ACCUM`, `cnt` 0, data 0, keep 0, timer 0.
  - `fifo_push` 0, `fifo_write_data` 0, `fifo_write_keep` 0, `in_ready` 1.
- Latency: a word closed at edge N asserts `fifo_push` in cycle N+1 if `fifo_full` is 0.
- Throughput: one input beat per cycle sustained while the FIFO is not full. No bubble at word boundaries.
- `fifo_full` affects `fifo_push` and `in_ready` combinationally in the same cycle. There is no registered path.
- Reset asserted mid-word or in `PENDING`: the partial or pending word is discarded, all registers go to reset values immediately, and no push occurs.

## Configuration

- `FF_FIFO_PACKER_FLUSH_TIMEOUT_EN` defined:
  - An idle counter runs in `ACCUM` with `cnt > 0`.
  - The counter clears on any accepted beat.
  - When it reaches `flush_timeout` cycles, the state moves to `PENDING` with the current lanes, and the counter clears.
- Not defined:
  - No timer logic is present. `flush_timeout` is ignored.
  - A partial word waits indefinitely for more beats or `in_last`.

## Structure

- Shared package `ff_fifo_packer_pkg`:
  - state enum `packer_state_t` (`ACCUM`, `PENDING`).
  - function `keep_mask(count, ratio)`.
- Sub-module `ff_fifo_packer_flush_timer`:
  - idle counter with `start`, `clear` and `expire`.
  - Instantiated only under the macro.

## Test plan

- `in_width=8`, `ratio=4`, beats 0x11, 0x22, 0x33, 0x44 back-to-back, `fifo_full=0`: one push one cycle after the 4th beat; data 0x44332211, keep 4'b1111.
- Beats 0xAA, 0xBB with `in_last` on 0xBB: push data 0x0000BBAA, keep 4'b0011. A single beat 0xCC with `in_last` gives keep 4'b0001, data 0x000000CC.
- Word pending with `fifo_full=1` for 5 cycles: `fifo_push=0`, `in_ready=0`, data stable. When `fifo_full` drops, exactly one push of the original data.
- Continuous 12-beat stream with `fifo_full=0`: 3 pushes. `in_ready` stays 1 throughout and beat 5 lands in lane 0 of word 2.
- `rst` pulsed after 2 beats: no push. The next 4 beats form a clean word with no stale lanes.
- With the macro and `flush_timeout=3`: one beat 0x5A then idle gives a push with keep 4'b0001 exactly 3 idle cycles plus 1 later. Without the macro: no push.
